// File: rtl/au_dec_carry.sv
// au_dec_carry: WIDTH-bit decrementer with carry-in and borrow-out.
//   z = (a - ci) mod 2^WIDTH, co = ci & (a == 0); outputs are registered.
//   ARCH selects the prefix-AND chain: 0 ripple, 1 Sklansky, 2 Brent-Kung
//   (other values use ripple). The result is the same for every ARCH value.
//   Define AU_DEC_C_INREG_EN to also register a/ci ahead of the core,
//   which raises the latency from 1 to 2 cycles.
module au_dec_carry #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             ci,
    output logic [WIDTH-1:0] z,
    output logic             co
);

    // Prefix nodes: x[0] = ci, x[i] = ~a[i-1]; p[i] = AND of x[0..i].
    // p[WIDTH] is the borrow-out.
    localparam int unsigned N    = WIDTH + 1;
    localparam int unsigned LVLS = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TOP  = 1 << (LVLS - 1);

    logic [WIDTH-1:0] core_a;
    logic             core_ci;
    logic [N-1:0]     x_c;
    logic [N-1:0]     p_c;
    logic [WIDTH-1:0] z_d, z_q;
    logic             co_d, co_q;

`ifdef AU_DEC_C_INREG_EN
    logic [WIDTH-1:0] a_q;
    logic             ci_q;

    // Optional input stage: operands are captured before the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            ci_q <= 1'b0;
        end else begin
            a_q  <= a;
            ci_q <= ci;
        end
    end

    assign core_a  = a_q;
    assign core_ci = ci_q;
`else
    assign core_a  = a;
    assign core_ci = ci;
`endif

    assign x_c = {~core_a, core_ci};

    generate
        if (ARCH == 1) begin : g_sklansky
            // Sklansky: at level l, every node with bit l set absorbs the
            // last node of the preceding 2^l block; depth ceil(log2 N).
            always_comb begin
                logic [N-1:0] t;
                t = x_c;
                for (int l = 0; l < int'(LVLS); l++) begin
                    for (int i = 0; i < int'(N); i++) begin
                        if (((i >> l) & 1) == 1) begin
                            t[i] = t[i] & t[((i >> l) << l) - 1];
                        end
                    end
                end
                p_c = t;
            end
        end else if (ARCH == 2) begin : g_brent_kung
            // Brent-Kung: up-sweep builds power-of-two block prefixes,
            // down-sweep fills the remaining nodes from them.
            always_comb begin
                logic [N-1:0] t;
                t = x_c;
                for (int d = 1; d < int'(N); d = d * 2) begin
                    for (int i = 2 * d - 1; i < int'(N); i = i + 2 * d) begin
                        t[i] = t[i] & t[i - d];
                    end
                end
                for (int d = int'(TOP); d >= 1; d = d / 2) begin
                    for (int i = 3 * d - 1; i < int'(N); i = i + 2 * d) begin
                        t[i] = t[i] & t[i - d];
                    end
                end
                p_c = t;
            end
        end else begin : g_ripple
            // Ripple: linear AND chain, depth WIDTH.
            always_comb begin
                logic [N-1:0] t;
                t    = x_c;
                for (int i = 1; i < int'(N); i++) begin
                    t[i] = t[i - 1] & x_c[i];
                end
                p_c = t;
            end
        end
    endgenerate

    // Each sum bit flips when the borrow reaches it.
    always_comb begin
        z_d  = core_a ^ p_c[WIDTH-1:0];
        co_d = p_c[N-1];
    end

    // Output register; reset clears the result and borrow immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q  <= '0;
            co_q <= 1'b0;
        end else begin
            z_q  <= z_d;
            co_q <= co_d;
        end
    end

    assign z  = z_q;
    assign co = co_q;

endmodule

// File: tb/tb_au_dec_carry.sv
// Self-checking bench for au_dec_carry (WIDTH = 8, all three ARCH variants).
module tb_au_dec_carry;

`ifdef AU_DEC_C_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] a_i;
    logic       ci_i;
    logic [7:0] z0, z1, z2;
    logic       co0, co1, co2;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [7:0] z;
        logic       co;
        string      nm;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic       ci;
        logic [7:0] ez;
        logic       eco;
    } vec_t;
    vec_t vecs[12];

    au_dec_carry #(.WIDTH(8), .ARCH(0)) u_dut0 (.clk(clk), .rst(rst), .a(a_i), .ci(ci_i), .z(z0), .co(co0));
    au_dec_carry #(.WIDTH(8), .ARCH(1)) u_dut1 (.clk(clk), .rst(rst), .a(a_i), .ci(ci_i), .z(z1), .co(co1));
    au_dec_carry #(.WIDTH(8), .ARCH(2)) u_dut2 (.clk(clk), .rst(rst), .a(a_i), .ci(ci_i), .z(z2), .co(co2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_one(input string nm, input int arch, input logic [7:0] z,
                             input logic co, input logic [7:0] ez, input logic eco);
        n_checks++;
        if (z !== ez || co !== eco) begin
            n_fail++;
            $display("FAIL %s arch%0d: got z=%h co=%b, expected z=%h co=%b", nm, arch, z, co, ez, eco);
        end
    endtask

    task automatic check(input string nm, input logic [7:0] ez, input logic eco);
        check_one(nm, 0, z0, co0, ez, eco);
        check_one(nm, 1, z1, co1, ez, eco);
        check_one(nm, 2, z2, co2, ez, eco);
    endtask

    // Drive one operand pair; compare the result that emerges LAT edges later.
    task automatic step(input logic [7:0] a, input logic ci, input logic [7:0] ez,
                        input logic eco, input string nm);
        exp_t e;
        @(negedge clk);
        a_i  = a;
        ci_i = ci;
        @(posedge clk);
        #1;
        exp_q.push_back('{z: ez, co: eco, nm: nm});
        if (exp_q.size() >= LAT) begin
            e = exp_q.pop_front();
            check(e.nm, e.z, e.co);
        end
    endtask

    // Independent arithmetic model: 9-bit subtraction, bit 8 is the borrow.
    task automatic step_model(input logic [7:0] a, input logic ci, input string nm);
        logic [8:0] r;
        r = {1'b0, a} - 9'(ci);
        step(a, ci, r[7:0], r[8], nm);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b0;
        a_i  = 8'h5A;
        ci_i = 1'b1;

        vecs[0]  = '{a: 8'h00, ci: 1'b1, ez: 8'hFF, eco: 1'b1};
        vecs[1]  = '{a: 8'h80, ci: 1'b1, ez: 8'h7F, eco: 1'b0};
        vecs[2]  = '{a: 8'hFF, ci: 1'b0, ez: 8'hFF, eco: 1'b0};
        vecs[3]  = '{a: 8'hFF, ci: 1'b1, ez: 8'hFE, eco: 1'b0};
        vecs[4]  = '{a: 8'h01, ci: 1'b1, ez: 8'h00, eco: 1'b0};
        vecs[5]  = '{a: 8'h10, ci: 1'b1, ez: 8'h0F, eco: 1'b0};
        vecs[6]  = '{a: 8'h00, ci: 1'b0, ez: 8'h00, eco: 1'b0};
        vecs[7]  = '{a: 8'h5A, ci: 1'b1, ez: 8'h59, eco: 1'b0};
        vecs[8]  = '{a: 8'h5A, ci: 1'b0, ez: 8'h5A, eco: 1'b0};
        vecs[9]  = '{a: 8'h02, ci: 1'b1, ez: 8'h01, eco: 1'b0};
        vecs[10] = '{a: 8'h7F, ci: 1'b1, ez: 8'h7E, eco: 1'b0};
        vecs[11] = '{a: 8'hC0, ci: 1'b1, ez: 8'hBF, eco: 1'b0};

        // Reset asserted with live inputs: outputs clear at once and stay clear.
        #2;
        rst = 1'b1;
        #1;
        check("reset_immediate", 8'h00, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_held", 8'h00, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();

        // Directed table, applied back-to-back.
        for (int k = 0; k < 12; k++) begin
            step(vecs[k].a, vecs[k].ci, vecs[k].ez, vecs[k].eco, $sformatf("vec%0d", k));
        end

        // Back-to-back decrement stream 01, 10, 00.
        step(8'h01, 1'b1, 8'h00, 1'b0, "b2b_01");
        step(8'h10, 1'b1, 8'h0F, 1'b0, "b2b_10");
        step(8'h00, 1'b1, 8'hFF, 1'b1, "b2b_00");

        // Reset pulsed mid-stream: in-flight data dropped, results resume.
        step(8'h33, 1'b1, 8'h32, 1'b0, "pre_rst");
        @(negedge clk);
        a_i  = 8'h44;
        ci_i = 1'b1;
        rst  = 1'b1;
        #1;
        check("midrst_immediate", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_held", 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        step(8'h00, 1'b1, 8'hFF, 1'b1, "post_rst0");
        step(8'h81, 1'b1, 8'h80, 1'b0, "post_rst1");

        // Exhaustive sweep over a and ci against the arithmetic model.
        for (int av = 0; av < 256; av++) begin
            for (int cv = 0; cv < 2; cv++) begin
                step_model(8'(av), 1'(cv), $sformatf("sweep_a%02h_ci%0d", av, cv));
            end
        end
        for (int k = 0; k < LAT - 1; k++) begin
            step(8'h00, 1'b0, 8'h00, 1'b0, "flush");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
